// File: rtl/booth_pkg.sv
// Shared definitions for the Booth-4 operand sequencer: default sizes and
// the sequencer FSM state encoding.
package booth_pkg;

  localparam int WIDTH_DEF   = 16;
  localparam int TIMEOUT_DEF = 64;
  localparam int CNT_W_DEF   = 7;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_SEND_M = 3'd2,
    ST_SEND_Q = 3'd3,
    ST_WAIT   = 3'd4,
    ST_REARM  = 3'd5
  } seq_state_e;

endpackage

// File: rtl/op_fifo2.sv
// Two-entry synchronous FIFO holding operand pairs ahead of the core.
// A push into a full FIFO is taken only when a pop happens on the same edge.
module op_fifo2 #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wr_data,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty
);

  logic [DW-1:0] mem_r [0:1];
  logic          wr_ptr_r;
  logic          rd_ptr_r;
  logic [1:0]    cnt_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign full      = (cnt_r == 2'd2);
  assign empty     = (cnt_r == 2'd0);
  assign do_push_s = push && (!full || pop);
  assign do_pop_s  = pop && !empty;
  assign rd_data   = mem_r[rd_ptr_r];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      cnt_r    <= 2'd0;
    end else begin
      if (do_push_s) wr_ptr_r <= ~wr_ptr_r;
      if (do_pop_s)  rd_ptr_r <= ~rd_ptr_r;
      case ({do_push_s, do_pop_s})
        2'b10:   cnt_r <= cnt_r + 2'd1;
        2'b01:   cnt_r <= cnt_r - 2'd1;
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Storage write on accepted push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_r[0] <= {DW{1'b0}};
      mem_r[1] <= {DW{1'b0}};
    end else if (do_push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

endmodule

// File: rtl/booth4_operand_sequencer.sv
// Feeds operand pairs to the radix-4 Booth core over its shared data bus,
// waits for done under a watchdog, collects the product and re-arms the core.
module booth4_operand_sequencer
  import booth_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               op_valid,
  output logic               op_ready,
  input  logic [WIDTH-1:0]   op_mcand,
  input  logic [WIDTH-1:0]   op_mplier,
  output logic               core_start,
  output logic [WIDTH-1:0]   core_data,
  input  logic               core_done,
  input  logic [2*WIDTH-1:0] core_prod,
  output logic               core_rearm,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [2*WIDTH-1:0] res_prod,
  output logic               err_timeout
);

  localparam int PW = 2 * WIDTH;
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

  seq_state_e        state_r;
  seq_state_e        next_s;
  logic              pop_s;
  logic              push_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic              wd_hit_s;
  logic [PW-1:0]     fifo_rd_s;
  logic [PW-1:0]     job_r;
  logic [CNT_W-1:0]  wd_r;
  logic              core_start_r;
  logic              core_rearm_r;
  logic [WIDTH-1:0]  core_data_r;
  logic              res_valid_r;
  logic [PW-1:0]     res_prod_r;
  logic              err_timeout_r;

  assign op_ready    = !fifo_full_s;
  assign push_s      = op_valid && !fifo_full_s;
  assign core_start  = core_start_r;
  assign core_rearm  = core_rearm_r;
  assign core_data   = core_data_r;
  assign res_valid   = res_valid_r;
  assign res_prod    = res_prod_r;
  assign err_timeout = err_timeout_r;
  assign wd_hit_s    = (wd_r == WD_LAST);

  op_fifo2 #(.DW(PW)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push_s),
    .pop     (pop_s),
    .wr_data ({op_mcand, op_mplier}),
    .rd_data (fifo_rd_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s)
  );

  // Next-state logic; a job is popped on the IDLE->START transition.
  always_comb begin
    next_s = state_r;
    pop_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!fifo_empty_s && !res_valid_r) begin
          next_s = ST_START;
          pop_s  = 1'b1;
        end else begin
          next_s = ST_IDLE;
        end
      end
      ST_START:  next_s = ST_SEND_M;
      ST_SEND_M: next_s = ST_SEND_Q;
      ST_SEND_Q: next_s = ST_WAIT;
      ST_WAIT: begin
        if (core_done || wd_hit_s) begin
          next_s = ST_REARM;
        end else begin
          next_s = ST_WAIT;
        end
      end
      ST_REARM:  next_s = ST_IDLE;
      default:   next_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= next_s;
  end

  // Core-side bus outputs, registered from the upcoming state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_start_r <= 1'b0;
      core_rearm_r <= 1'b0;
      core_data_r  <= {WIDTH{1'b0}};
      job_r        <= {PW{1'b0}};
    end else begin
      core_start_r <= (next_s == ST_START);
      core_rearm_r <= (next_s == ST_REARM);
      if (pop_s) job_r <= fifo_rd_s;
      case (next_s)
        ST_START:  core_data_r <= fifo_rd_s[PW-1:WIDTH];
        ST_SEND_M: core_data_r <= job_r[PW-1:WIDTH];
        ST_SEND_Q: core_data_r <= job_r[WIDTH-1:0];
        default:   core_data_r <= core_data_r;
      endcase
    end
  end

  // Watchdog: cleared as Q is sent, counts every cycle spent waiting for done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_r <= {CNT_W{1'b0}};
    end else if (state_r == ST_SEND_Q) begin
      wd_r <= {CNT_W{1'b0}};
    end else if (state_r == ST_WAIT) begin
      wd_r <= wd_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Result capture and handshake; done wins over a same-cycle watchdog expiry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_r   <= 1'b0;
      res_prod_r    <= {PW{1'b0}};
      err_timeout_r <= 1'b0;
    end else begin
      if (state_r == ST_WAIT && core_done) begin
        res_valid_r <= 1'b1;
        res_prod_r  <= core_prod;
      end else if (res_valid_r && res_ready) begin
        res_valid_r <= 1'b0;
      end
      if (state_r == ST_WAIT && !core_done && wd_hit_s) begin
        err_timeout_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_booth4_operand_sequencer.sv
// Scoreboard bench for booth4_operand_sequencer with a behavioural Booth core:
// done rises a programmable number of cycles after Q load, product = signed M*Q.
module tb_booth4_operand_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        op_valid;
  logic        op_ready;
  logic [15:0] op_mcand;
  logic [15:0] op_mplier;
  logic        core_start;
  logic [15:0] core_data;
  logic        core_done;
  logic [31:0] core_prod;
  logic        core_rearm;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_prod;
  logic        err_timeout;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int start_cnt = 0;
  int rearm_cnt = 0;
  int lat = 18;
  int nodone_job = -1;
  logic [31:0] exp_q[$];

  // core model state
  logic [1:0]         ph;
  logic [15:0]        m_r;
  logic               busy;
  logic               cur_nodone;
  logic               done_r;
  logic signed [31:0] prod_r;
  int                 cnt;
  int                 jobs_loaded = 0;
  int                 qload_cyc = 0;

  assign core_done = done_r;
  assign core_prod = prod_r;

  booth4_operand_sequencer dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
    .op_mcand(op_mcand), .op_mplier(op_mplier), .core_start(core_start),
    .core_data(core_data), .core_done(core_done), .core_prod(core_prod),
    .core_rearm(core_rearm), .res_valid(res_valid), .res_ready(res_ready),
    .res_prod(res_prod), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // cycle counter and pulse counters
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && core_start) start_cnt <= start_cnt + 1;
    if (rst_n && core_rearm) rearm_cnt <= rearm_cnt + 1;
  end

  // behavioural Booth core: M loaded the edge after start, Q the edge after that
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph <= 2'd0; busy <= 1'b0; done_r <= 1'b0; cnt <= 0;
      m_r <= 16'h0000; prod_r <= 32'sd0; cur_nodone <= 1'b0;
    end else if (core_rearm) begin
      done_r <= 1'b0; busy <= 1'b0; ph <= 2'd0;
    end else begin
      if (core_start) begin
        ph <= 2'd1;
      end else if (ph == 2'd1) begin
        m_r <= core_data; ph <= 2'd2;
      end else if (ph == 2'd2) begin
        prod_r      <= $signed(m_r) * $signed(core_data);
        ph          <= 2'd0;
        cnt         <= lat;
        busy        <= 1'b1;
        cur_nodone  <= (jobs_loaded == nodone_job);
        jobs_loaded <= jobs_loaded + 1;
        qload_cyc   <= cyc + 1;
      end
      if (busy && !cur_nodone) begin
        if (cnt == 1) begin
          done_r <= 1'b1; busy <= 1'b0;
        end
        cnt <= cnt - 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // scoreboard monitor: compare each product as it is handed off
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_result: got %h expected none", res_prod);
      end else begin
        chk("result", res_prod, exp_q.pop_front());
      end
    end
  end

  task automatic push(input logic [15:0] a, input logic [15:0] b,
                      input logic [31:0] e, input bit en);
    int n = 0;
    @(negedge clk);
    op_valid = 1'b1; op_mcand = a; op_mplier = b;
    while (!op_ready && n < 300) begin
      @(negedge clk); n++;
    end
    if (!op_ready) begin
      tests++; fails++;
      $display("FAIL push_timeout: got op_ready=0 expected 1");
    end
    @(posedge clk);
    if (en) exp_q.push_back(e);
    #1 op_valid = 1'b0;
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while ((exp_q.size() != 0 || res_valid) && n < limit) begin
      @(negedge clk); n++;
    end
    chk("drain_left", exp_q.size(), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_op_ready"}, op_ready, 32'd1);
    chk({tag, "_core_start"}, core_start, 32'd0);
    chk({tag, "_core_data"}, core_data, 32'd0);
    chk({tag, "_core_rearm"}, core_rearm, 32'd0);
    chk({tag, "_res_valid"}, res_valid, 32'd0);
    chk({tag, "_res_prod"}, res_prod, 32'd0);
    chk({tag, "_err"}, err_timeout, 32'd0);
  endtask

  initial begin
    int s0, r0, n;
    rst_n = 1'b0; op_valid = 1'b0; op_mcand = 16'h0; op_mplier = 16'h0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst");
    rst_n = 1'b1;

    // 1: basic job, bus protocol timing
    res_ready = 1'b1; r0 = rearm_cnt;
    push(16'd3, 16'd5, 32'h0000000F, 1'b1);
    @(negedge clk); chk("t1_start_early", core_start, 32'd0);
    @(negedge clk); chk("t1_start", core_start, 32'd1); chk("t1_data_m0", core_data, 32'd3);
    @(negedge clk); chk("t1_start_off", core_start, 32'd0); chk("t1_data_m1", core_data, 32'd3);
    @(negedge clk); chk("t1_data_q", core_data, 32'd5);
    drain(100);
    chk("t1_rearms", rearm_cnt - r0, 32'd1);

    // 2: negative multiplicand
    push(16'hFFFE, 16'd7, 32'hFFFFFFF2, 1'b1);
    drain(100);
    chk("t2_err", err_timeout, 32'd0);

    // 3: back-pressure, FIFO fill, in-order results
    res_ready = 1'b0; s0 = start_cnt;
    push(16'hFFFF, 16'hFFFF, 32'h00000001, 1'b1);
    push(16'h7FFF, 16'h7FFF, 32'h3FFF0001, 1'b1);
    push(16'h8000, 16'h8000, 32'h40000000, 1'b1);
    @(negedge clk); chk("t3_op_ready_full", op_ready, 32'd0);
    repeat (40) @(negedge clk);
    chk("t3_single_start", start_cnt - s0, 32'd1);
    chk("t3_held_valid", res_valid, 32'd1);
    chk("t3_held_prod", res_prod, 32'h00000001);
    res_ready = 1'b1;
    drain(300);
    chk("t3_starts", start_cnt - s0, 32'd3);

    // 5: done coincides with the last watchdog count
    lat = 63;
    push(16'd100, 16'hFFFD, 32'hFFFFFED4, 1'b1);
    drain(300);
    chk("t5_err", err_timeout, 32'd0);
    lat = 18;

    // 4: core never finishes job 6; job 7 runs normally afterwards
    nodone_job = 6; r0 = rearm_cnt;
    push(16'd2, 16'd2, 32'h0, 1'b0);
    push(16'd4, 16'hFFFB, 32'hFFFFFFEC, 1'b1);
    n = 0;
    while (!err_timeout && n < 300) begin
      @(negedge clk); n++;
    end
    chk("t4_err_set", err_timeout, 32'd1);
    chk("t4_wait_cycles", cyc - qload_cyc, 32'd64);
    drain(200);
    chk("t4_rearms", rearm_cnt - r0, 32'd2);
    chk("t4_err_sticky", err_timeout, 32'd1);

    // 6: reset in the middle of WAIT
    push(16'd9, 16'd9, 32'h0, 1'b0);
    repeat (10) @(negedge clk);
    s0 = start_cnt;
    rst_n = 1'b0;
    #1 chk_reset_outputs("t6");
    @(negedge clk); rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("t6_no_start", start_cnt - s0, 32'd0);
    chk("t6_no_valid", res_valid, 32'd0);
    chk("t6_op_ready", op_ready, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
